// File: rtl/pe_arb_pkg.sv
// Shared types and helpers for the PE link arbiter.
package pe_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Bits needed to index n requesters (at least 1).
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    // Round-robin successor of idx, wrapping to 0 at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pe_rr_pick.sv
// Combinational round-robin finder: first set bit of valid_i scanning
// upward from ptr_i with wraparound.
module pe_rr_pick
    import pe_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan ptr_i, ptr_i+1, ... and keep the first valid candidate.
    always_comb begin
        int cand;
        cand  = 0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any_o && valid_i[IDX_W'(cand)]) begin
                idx_o = IDX_W'(cand);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_link_arbiter.sv
// Round-robin, packet-locked arbiter for one outbound mesh link.
// A granted requester owns the link until its last beat is accepted;
// ap_start freezes arbitration and intake while the output slot drains.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin (no beat accepted)
// BUSY  | grant_idx owns the link; beats flow into the output slot
module pe_link_arbiter
    import pe_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 130,
    parameter int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ap_start,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [IDX_W-1:0]              out_src,
    input  logic                          out_ready,
    output logic                          grant_busy
);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [IDX_W-1:0]      out_src_q, out_src_d;

    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  can_accept;
    logic                  accept;

    pe_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Ready depends only on registered state and link-side inputs, never on req_valid.
    assign can_accept = (state_q == BUSY) && ap_start && (!out_valid_q || out_ready);
    assign accept     = can_accept && sel_valid;

    // Route the granted requester's beat toward the output slot.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = can_accept;
            end
        end
    end

    // Next-state for arbitration and the single-entry output slot.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                if (ap_start && pick_any) begin
                    grant_idx_d = pick_idx;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDX_W'(rr_next(int'(grant_idx_q), NUM_REQ));
                end
            end
        endcase

        // A load while draining keeps the slot full for one-beat-per-cycle throughput.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant_idx_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign out_src    = out_src_q;
    assign grant_busy = (state_q == BUSY);

endmodule

// File: doc/pe_link_arbiter.md
# pe_link_arbiter

Round-robin, packet-locked arbiter sharing one outbound mesh link (e.g. a PE tile's east/south output) among NUM_REQ local requesters. Sits between the requesting engines inside a tile and the tile's registered link output. Once granted, a requester keeps the link until its `last` beat is accepted. `ap_start` gates all forward progress, matching the tile-level start/hold semantics of the mesh.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 130, link payload width
- IDX_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  **synchronous, active-low**; reset==0 at a clk edge resets all state
- ap_start  in  1  run enable; 0 = freeze arbitration and intake
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  final beat of packet
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] & req_ready[i]
- out_valid  out  1  link output valid (registered)
- out_data  out  DATA_WIDTH  link payload (registered)
- out_last  out  1  final beat marker (registered)
- out_src  out  IDX_W  index of requester owning out_data (registered)
- out_ready  in  1  downstream accept
- grant_busy  out  1  1 while a packet holds the link

## Operation
- States: IDLE, BUSY. Registers: state, grant_idx, rr_ptr, output slot (out_valid/data/last/src).
- IDLE: if ap_start=1 and any req_valid, pick first requester with valid set scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ); latch grant_idx, go BUSY, grant_busy=1. No beat accepted in IDLE.
- BUSY: req_ready[grant_idx] = ap_start & (!out_valid | out_ready); all other req_ready=0. Accepted beat loads the output slot with out_src=grant_idx.
- Accepting a beat with req_last=1: go IDLE, rr_ptr <= grant_idx+1 (wrap to 0 at NUM_REQ), grant_busy=0 next cycle.
- Granted requester deasserting valid mid-packet: link stays locked; bubbles only; no regrant until its last beat.
- Output slot: out_valid cleared on out_ready when no new beat loads; simultaneous drain and load keeps out_valid=1 with new data (full throughput, one beat/cycle).
- ap_start=0: no grant decision, req_ready all 0, state/grant_idx/rr_ptr held; output slot still drains on out_ready.
- Non-granted requesters must hold valid/data stable until accepted; the arbiter does not buffer them.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, out_valid=0, out_data=0, out_last=0, out_src=0, grant_busy=0, req_ready=0.
- Reset mid-packet: packet aborted, all of the above restored on that edge; in-flight out_valid dropped.
- Latency: req_valid rising in IDLE at cycle 0 → grant at edge 1 → first beat accepted cycle 1 → out_valid at cycle 2.
- Arbitration bubble: exactly 1 cycle between packets (IDLE cycle), including back-to-back packets from the same requester.
- Single-beat packet (req_last on first beat): BUSY for 1 cycle when out_ready=1.
- req_ready is combinational from state, grant_idx, out_valid, out_ready, ap_start; no combinational path from req_valid to req_ready.

## Structure
- Package pe_arb_pkg: state enum {IDLE, BUSY}, function idx_width(n), function rr_next(idx, n).
- Sub-module pe_rr_pick: combinational round-robin first-set finder (inputs valid vector and rr_ptr; outputs index and any). Everything else in pe_link_arbiter.

## Test plan
- Reset: hold reset=0 3 cycles with all req_valid=1 → all outputs 0, req_ready=0; release → first grant to requester 0.
- Fairness: all 4 requesters send continuous 1-beat packets, out_ready=1 → out_src sequence 0,1,2,3,0,... with one idle cycle between beats.
- Packet lock: req 2 sends 3-beat packet (A,B,C, last on C), req 0 valid throughout → out_data A,B,C all out_src=2, then req 0 granted; rr_ptr=3 so req 3 would win over 0 if valid.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_data held stable, req_ready=0 after slot fills; release → no beat lost or duplicated.
- ap_start=0 for 4 cycles in BUSY with out_valid=1, out_ready=1 → slot drains once, no new beats, grant_idx unchanged; ap_start=1 resumes same packet.
- Reset mid-packet on beat 2 of 4 → out_valid=0 next cycle, state IDLE, rr_ptr=0.
